// File: rtl/dcache_load_responder.sv
// Direct-mapped, blocking, load-only data cache: same-cycle hit response, one outstanding miss.
// Optional feature macro DCACHE_FILL_FORWARD_EN: forward fill data to a matching request in the fill cycle.
module dcache_load_responder #(
  parameter  int NUM_LINES = 8,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_req,
  input  logic [24:0] load_addr,
  input  logic        flush,
  output logic [64:0] hit_data,
  output logic        mem_req_valid,
  output logic [21:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        busy,
  output logic [31:0] miss_count
);

  localparam int BLK_W = 22;
  localparam int OFS_W = 3;
  localparam int TAG_W = BLK_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state, state_nxt;

  logic             line_valid [NUM_LINES];
  logic [TAG_W-1:0] line_tag   [NUM_LINES];
  logic [63:0]      line_data  [NUM_LINES];

  logic [BLK_W-1:0] pend_addr;
  logic [BLK_W-1:0] req_blk;
  logic [IDX_W-1:0] req_idx, pend_idx;
  logic [TAG_W-1:0] req_tag, pend_tag;
  logic             hit, fill, miss_start;
  logic             unused_ofs;

  // Byte offset within the 64-bit block never affects the lookup.
  assign req_blk    = load_addr[BLK_W+OFS_W-1:OFS_W];
  assign unused_ofs = ^load_addr[OFS_W-1:0];
  assign req_idx    = req_blk[IDX_W-1:0];
  assign req_tag    = req_blk[BLK_W-1:IDX_W];
  assign pend_idx   = pend_addr[IDX_W-1:0];
  assign pend_tag   = pend_addr[BLK_W-1:IDX_W];

  assign hit        = load_req && line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign fill       = (state == S_WAIT) && mem_resp_valid;
  assign miss_start = (state == S_IDLE) && load_req && !hit && !flush;

  // NOTE: sequential state uses non-blocking (<=), combinational logic uses blocking (=).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss_start)    state_nxt = S_REQ;
      S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (mem_resp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    busy          = (state != S_IDLE);
    hit_data      = '0;
    if (state == S_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = pend_addr;
    end
    if (hit) hit_data = {1'b1, line_data[req_idx]};
`ifdef DCACHE_FILL_FORWARD_EN
    if (fill && load_req && (req_blk == pend_addr)) hit_data = {1'b1, mem_resp_data};
`endif
  end

  // Flush clears everything, but an in-flight fill landing the same edge still installs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) line_valid[i] <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < NUM_LINES; i++) line_valid[i] <= 1'b0;
      end
      if (fill) line_valid[pend_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone qualify their contents.
  always_ff @(posedge clock) begin
    if (reset_n && fill) begin
      line_tag[pend_idx]  <= pend_tag;
      line_data[pend_idx] <= mem_resp_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_addr  <= '0;
      miss_count <= '0;
    end else if (miss_start) begin
      pend_addr <= req_blk;
      if (miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dcache_load_responder.sv
// Randomised + directed bench for dcache_load_responder: a line-level cache model predicts
// every cycle's outputs into a scoreboard queue that a negedge monitor drains and compares.
module tb_dcache_load_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_req;
  logic [24:0] load_addr;
  logic        flush;
  logic [64:0] hit_data;
  logic        mem_req_valid;
  logic [21:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        busy;
  logic [31:0] miss_count;

  dcache_load_responder dut (
    .clock(clock), .reset_n(reset_n), .load_req(load_req), .load_addr(load_addr),
    .flush(flush), .hit_data(hit_data), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [64:0] hit_data;
    logic        mrv;
    logic [21:0] mra;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   push_en = 0;

  // Reference model: resident block per line, miss phase 0=idle 1=requesting 2=awaiting data.
  bit          m_valid [8];
  logic [21:0] m_blk   [8];
  logic [63:0] m_data  [8];
  int          m_phase = 0;
  logic [21:0] m_pend  = '0;
  logic [31:0] m_cnt   = '0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hit_data", hit_data, e.hit_data);
        check("mem_req_valid", 65'(mem_req_valid), 65'(e.mrv));
        if (e.mrv) check("mem_req_addr", 65'(mem_req_addr), 65'(e.mra));
        check("busy", 65'(busy), 65'(e.busy));
        check("miss_count", 65'(miss_count), 65'(e.cnt));
      end
    end
  end

  task automatic step(input bit req, input logic [21:0] blk, input bit fl, input bit rdy,
                      input bit rv, input logic [63:0] rd, input bit rst_v);
    exp_t e;
    int   idx;
    bit   hit;
    load_req       = req;
    load_addr      = {blk, 3'($urandom)};
    flush          = fl;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    reset_n        = rst_v;
    idx = int'(blk[2:0]);
    hit = req && m_valid[idx] && (m_blk[idx] == blk);
    e.hit_data = hit ? {1'b1, m_data[idx]} : 65'd0;
`ifdef DCACHE_FILL_FORWARD_EN
    if (m_phase == 2 && rv && req && blk == m_pend) e.hit_data = {1'b1, rd};
`endif
    e.mrv  = (m_phase == 1);
    e.mra  = m_pend;
    e.busy = (m_phase != 0);
    e.cnt  = m_cnt;
    if (push_en) sb.push_back(e);
    @(posedge clock);
    #1;
    if (!rst_v) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_phase = 0;
      m_pend  = '0;
      m_cnt   = '0;
    end else begin
      if (fl) foreach (m_valid[i]) m_valid[i] = 0;
      if (m_phase == 0) begin
        if (req && !hit && !fl) begin
          m_phase = 1;
          m_pend  = blk;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
      end else if (m_phase == 1) begin
        if (rdy) m_phase = 2;
      end else if (rv) begin
        m_valid[m_pend[2:0]] = 1;
        m_blk[m_pend[2:0]]   = m_pend;
        m_data[m_pend[2:0]]  = rd;
        m_phase = 0;
      end
    end
  endtask

  // Miss from idle, immediate accept, data three cycles after the request, then the hit.
  task automatic fetch(input logic [21:0] blk, input logic [63:0] d);
    step(1, blk, 0, 0, 0, '0, 1);
    step(1, blk, 0, 1, 0, '0, 1);
    step(1, blk, 0, 0, 0, '0, 1);
    step(1, blk, 0, 0, 0, '0, 1);
    step(1, blk, 0, 0, 1, d,  1);
    step(1, blk, 0, 0, 0, '0, 1);
  endtask

  initial begin
    int          lat;
    bit          req, fl, rdy, rv, rst_v;
    logic [21:0] blk;
    logic [63:0] rd;

    step(0, '0, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 0, '0, 0);
    push_en = 1;
    step(0, '0, 0, 0, 0, '0, 1);

    // Basic miss/fill/hit, then same-index eviction and refetch.
    fetch(22'h00010, 64'hDEAD_BEEF_0123_4567);
    fetch(22'h00018, 64'h1111_2222_3333_4444);
    fetch(22'h00010, 64'h5555_6666_7777_8888);

    // Stalled request: other misses ignored, resident lines still hit.
    fetch(22'h00021, 64'hA5A5_0000_FFFF_5A5A);
    step(1, 22'h00033, 0, 0, 0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, (i % 2) ? 22'h00005 : 22'h00021, 0, 0, 0, '0, 1);
    step(1, 22'h00033, 0, 1, 1, 64'hBAD0_BAD0_BAD0_BAD0, 1);
    step(1, 22'h00021, 0, 0, 0, '0, 1);
    step(1, 22'h00033, 0, 0, 1, 64'h0033_0033_0033_0033, 1);
    step(1, 22'h00033, 0, 0, 0, '0, 1);

    // Reset while awaiting data: late fill is dropped, line still misses.
    step(1, 22'h00007, 0, 0, 0, '0, 1);
    step(1, 22'h00007, 0, 1, 0, '0, 1);
    step(1, 22'h00007, 0, 0, 0, '0, 0);
    step(0, 22'h00007, 0, 0, 1, 64'hCAFE_CAFE_CAFE_CAFE, 1);
    step(1, 22'h00007, 0, 0, 0, '0, 1);
    step(1, 22'h00007, 0, 1, 0, '0, 1);
    step(1, 22'h00007, 0, 0, 1, 64'h7777_0000_7777_0000, 1);

    // Flush during the wait: only the incoming fill survives.
    fetch(22'h00002, 64'h0202_0202_0202_0202);
    step(1, 22'h00004, 0, 0, 0, '0, 1);
    step(1, 22'h00004, 0, 1, 0, '0, 1);
    step(1, 22'h00004, 1, 0, 0, '0, 1);
    step(1, 22'h00004, 0, 0, 1, 64'h0404_0404_0404_0404, 1);
    step(1, 22'h00004, 0, 0, 0, '0, 1);
    step(1, 22'h00002, 0, 0, 0, '0, 1);
    step(1, 22'h00007, 0, 0, 0, '0, 1);

    // Random traffic over a small block pool so hits, evictions and stalls all recur.
    lat = 0;
    for (int c = 0; c < 4000; c++) begin
      req   = ($urandom_range(0, 3) != 0);
      blk   = 22'(($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
      fl    = ($urandom_range(0, 39) == 0);
      rst_v = ($urandom_range(0, 299) != 0);
      rdy   = $urandom_range(0, 1) != 0;
      rd    = {$urandom, $urandom};
      if (m_phase == 2) begin
        rv = (lat == 0);
        lat = (lat == 0) ? $urandom_range(0, 4) : lat - 1;
      end else begin
        rv = ($urandom_range(0, 7) == 0);
      end
      step(req, blk, fl, rdy, rv, rd, rst_v);
    end

    @(negedge clock);
    #1;
    check("scoreboard_drain", 65'(sb.size()), 65'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
